// File: rtl/reg_cmd_ctrl_if.sv
// Bundle between reg_cmd_ctrl and its surroundings: UART rx/tx
// byte handshakes plus the register-file write/read port.
//   master : the controller (drives strobes, address, data, tx byte, ERR)
//   slave  : UART + register file side (drives rx byte, TX_BUSY, RdData)
interface reg_cmd_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 3
);
  logic [7:0]       RX_P_DATA;
  logic             RX_D_VLD;
  logic             TX_BUSY;
  logic [WIDTH-1:0] RdData;
  logic             WrEn;
  logic             RdEn;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData;
  logic [7:0]       TX_P_DATA;
  logic             TX_D_VLD;
  logic             ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, TX_BUSY, RdData,
    output WrEn, RdEn, Address, WrData,
    output TX_P_DATA, TX_D_VLD, ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, TX_BUSY, RdData,
    input  WrEn, RdEn, Address, WrData,
    input  TX_P_DATA, TX_D_VLD, ERR
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Register command controller: decodes UART frames (AA addr data.. /
// BB addr), strobes the register file, streams read data back LSB first.
// Ports: clk, rst (async, active-high), bus (reg_cmd_ctrl_if.master).
// Option: define REG_CMD_CTRL_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYC cycles without a received byte.
module reg_cmd_ctrl #(
  parameter int WIDTH       = 16,
  parameter int ADDR        = 3,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst,
  reg_cmd_ctrl_if.master  bus
);
  localparam int BYTES = WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [1:0]       LAT_LAST  = 2'(RD_LAT - 1);

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] W_ADDR = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] R_ADDR = 3'd4;
  localparam logic [2:0] READ   = 3'd5;
  localparam logic [2:0] R_WAIT = 3'd6;
  localparam logic [2:0] SEND   = 3'd7;

  if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > 32) begin : gBadWidth
    $error("reg_cmd_ctrl: WIDTH must be 8, 16, 24 or 32");
  end
  if (ADDR < 1 || ADDR > 8) begin : gBadAddr
    $error("reg_cmd_ctrl: ADDR must be 1..8");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : gBadLat
    $error("reg_cmd_ctrl: RD_LAT must be 1..3");
  end
  if (TIMEOUT_CYC < 1) begin : gBadTo
    $error("reg_cmd_ctrl: TIMEOUT_CYC must be >= 1");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] byteCnt;
  logic [1:0]       latCnt;
  logic [ADDR-1:0]  addrQ;
  logic [WIDTH-1:0] wrDataQ;
  logic [WIDTH-1:0] capQ;
  logic             errQ;

  logic       rxVld;
  logic [7:0] rxByte;
  logic       addrBad;
  logic       waiting;
  logic       toHit;
  logic [7:0] txByte;

  assign rxVld  = bus.RX_D_VLD;
  assign rxByte = bus.RX_P_DATA;

  // compare in 32 bits so ADDR = 8 (DEPTH = 256) needs no special case
  assign addrBad = ({24'd0, rxByte} >= 32'(DEPTH));

  // states in which the FSM is mid-frame, waiting on the next rx byte
  assign waiting = (state == W_ADDR) ||
                   (state == W_DATA) ||
                   (state == R_ADDR);

`ifdef REG_CMD_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] toCnt;

  // toCnt = idle cycles already spent; hit on the TIMEOUT_CYC-th one
  assign toHit = waiting && !rxVld && (toCnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt <= '0;
    end else if (!waiting || rxVld || toHit) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCnt + TO_W'(1);
    end
  end
`else
  assign toHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      byteCnt <= '0;
      latCnt  <= '0;
      addrQ   <= '0;
      wrDataQ <= '0;
      capQ    <= '0;
      errQ    <= 1'b0;
    end else begin
      errQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rxVld) begin
            unique case (1'b1)
              (rxByte == CMD_WR): state <= W_ADDR;
              (rxByte == CMD_RD): state <= R_ADDR;
              default:            errQ  <= 1'b1;
            endcase
          end
        end

        W_ADDR, R_ADDR: begin
          if (rxVld) begin
            if (addrBad) begin
              errQ  <= 1'b1;
              state <= IDLE;
            end else begin
              addrQ   <= rxByte[ADDR-1:0];
              byteCnt <= '0;
              state   <= (state == W_ADDR) ? W_DATA : READ;
            end
          end else if (toHit) begin
            errQ  <= 1'b1;
            state <= IDLE;
          end
        end

        W_DATA: begin
          if (rxVld) begin
            for (int k = 0; k < BYTES; k++) begin
              if (byteCnt == CNT_W'(k)) begin
                wrDataQ[8*k +: 8] <= rxByte;
              end
            end
            if (byteCnt == LAST_BYTE) begin
              byteCnt <= '0;
              state   <= WRITE;
            end else begin
              byteCnt <= byteCnt + CNT_W'(1);
            end
          end else if (toHit) begin
            errQ  <= 1'b1;
            state <= IDLE;
          end
        end

        WRITE: begin
          errQ  <= rxVld;
          state <= IDLE;
        end

        READ: begin
          errQ   <= rxVld;
          latCnt <= '0;
          state  <= R_WAIT;
        end

        // RdData is valid after RD_LAT edges counted from the RdEn edge
        R_WAIT: begin
          errQ <= rxVld;
          if (latCnt == LAT_LAST) begin
            capQ    <= bus.RdData;
            byteCnt <= '0;
            state   <= SEND;
          end else begin
            latCnt <= latCnt + 2'd1;
          end
        end

        SEND: begin
          errQ <= rxVld;
          if (!bus.TX_BUSY) begin
            if (byteCnt == LAST_BYTE) begin
              byteCnt <= '0;
              state   <= IDLE;
            end else begin
              byteCnt <= byteCnt + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    txByte = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      if (byteCnt == CNT_W'(k)) begin
        txByte = capQ[8*k +: 8];
      end
    end
  end

  assign bus.WrEn      = (state == WRITE);
  assign bus.RdEn      = (state == READ);
  assign bus.Address   = addrQ;
  assign bus.WrData    = wrDataQ;
  assign bus.TX_D_VLD  = (state == SEND);
  assign bus.TX_P_DATA = (state == SEND) ? txByte : 8'h00;
  assign bus.ERR       = errQ;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: frame writes/reads against a small
// register-file stub, tx backpressure, error frames, mid-frame reset.
module tb_reg_cmd_ctrl;
  localparam int WIDTH  = 16;
  localparam int ADDR   = 3;
  localparam int RD_LAT = 1;
`ifdef REG_CMD_CTRL_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic clk;
  logic rst;

  reg_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  reg_cmd_ctrl #(
    .WIDTH(WIDTH),
    .ADDR(ADDR),
    .RD_LAT(RD_LAT),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [2**ADDR];
  logic [WIDTH-1:0] rdPipe;

  initial begin
    for (int i = 0; i < 2**ADDR; i++) mem[i] = '0;
    rdPipe = '0;
  end

  always @(posedge clk) begin
    if (bus.WrEn) mem[bus.Address] <= bus.WrData;
    if (bus.RdEn) rdPipe <= mem[bus.Address];
  end

  assign bus.RdData = rdPipe;

  int nCmp;
  int nBad;
  int wrCnt;
  int rdCnt;
  int errCnt;
  int bothCnt;
  logic [ADDR-1:0]  lastWrAddr;
  logic [WIDTH-1:0] lastWrData;
  logic [ADDR-1:0]  lastRdAddr;
  logic [7:0]       txQ [$];

  always @(negedge clk) begin
    if (bus.WrEn) begin
      wrCnt++;
      lastWrAddr = bus.Address;
      lastWrData = bus.WrData;
    end
    if (bus.RdEn) begin
      rdCnt++;
      lastRdAddr = bus.Address;
    end
    if (bus.WrEn && bus.RdEn) bothCnt++;
    if (bus.ERR) errCnt++;
    if (bus.TX_D_VLD && !bus.TX_BUSY) txQ.push_back(bus.TX_P_DATA);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clrMon();
    wrCnt  = 0;
    rdCnt  = 0;
    errCnt = 0;
    txQ.delete();
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    step(1);
    bus.RX_D_VLD  = 1'b0;
    step(1);
  endtask

  function automatic logic [7:0] txAt(input int i);
    if (i < txQ.size()) return txQ[i];
    return 8'hEE;
  endfunction

  task automatic waitTx(input int n);
    int k = 0;
    while (txQ.size() < n && k < 60) begin
      step(1);
      k++;
    end
    step(3);
  endtask

  task automatic waitTxVld();
    int k = 0;
    while (!bus.TX_D_VLD && k < 40) begin
      step(1);
      k++;
    end
    chk("tx_vld_seen", 32'(bus.TX_D_VLD), 32'd1);
  endtask

  task automatic doWrite(input string tag,
                         input logic [7:0] a,
                         input logic [7:0] d0,
                         input logic [7:0] d1,
                         input logic [15:0] expD);
    clrMon();
    sendByte(8'hAA);
    sendByte(a);
    sendByte(d0);
    sendByte(d1);
    step(3);
    chk({tag, "_wren"}, 32'(wrCnt), 32'd1);
    chk({tag, "_addr"}, 32'(lastWrAddr), 32'(a));
    chk({tag, "_data"}, 32'(lastWrData), 32'(expD));
    chk({tag, "_err"}, 32'(errCnt), 32'd0);
  endtask

  task automatic doRead(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] e0,
                        input logic [7:0] e1);
    clrMon();
    sendByte(8'hBB);
    sendByte(a);
    waitTx(2);
    chk({tag, "_rden"}, 32'(rdCnt), 32'd1);
    chk({tag, "_addr"}, 32'(lastRdAddr), 32'(a));
    chk({tag, "_ntx"}, 32'(txQ.size()), 32'd2);
    chk({tag, "_tx0"}, 32'(txAt(0)), 32'(e0));
    chk({tag, "_tx1"}, 32'(txAt(1)), 32'(e1));
    chk({tag, "_wren"}, 32'(wrCnt), 32'd0);
  endtask

  initial begin
    int holdBad;
    nCmp = 0;
    nBad = 0;
    bothCnt = 0;
    lastWrAddr = '0;
    lastWrData = '0;
    lastRdAddr = '0;
    clrMon();
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    bus.TX_BUSY   = 1'b0;
    rst = 1'b1;
    step(3);
    chk("rst_outs",
        32'({bus.WrEn, bus.RdEn, bus.Address, bus.WrData,
             bus.TX_P_DATA, bus.TX_D_VLD, bus.ERR}), 32'd0);
    rst = 1'b0;
    step(2);

    doWrite("wr3", 8'h03, 8'h0B, 8'h00, 16'h000B);
    doWrite("wr7", 8'h07, 8'h01, 8'h00, 16'h0001);
    doWrite("wr1", 8'h01, 8'h1C, 8'h00, 16'h001C);

    doRead("rd3", 8'h03, 8'h0B, 8'h00);
    doRead("rd1", 8'h01, 8'h1C, 8'h00);
    doRead("rd7", 8'h07, 8'h01, 8'h00);

    clrMon();
    bus.TX_BUSY = 1'b1;
    sendByte(8'hBB);
    sendByte(8'h01);
    waitTxVld();
    holdBad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.TX_D_VLD || bus.TX_P_DATA != 8'h1C) holdBad++;
      step(1);
    end
    chk("bp_hold", 32'(holdBad), 32'd0);
    chk("bp_none_while_busy", 32'(txQ.size()), 32'd0);
    bus.TX_BUSY = 1'b0;
    waitTx(2);
    chk("bp_ntx", 32'(txQ.size()), 32'd2);
    chk("bp_tx0", 32'(txAt(0)), 32'h1C);
    chk("bp_tx1", 32'(txAt(1)), 32'h00);

    clrMon();
    sendByte(8'h55);
    step(2);
    chk("bad_cmd_err", 32'(errCnt), 32'd1);
    chk("bad_cmd_strobe", 32'(wrCnt + rdCnt), 32'd0);

    clrMon();
    sendByte(8'hAA);
    sendByte(8'h09);
    step(2);
    chk("bad_addr_err", 32'(errCnt), 32'd1);
    chk("bad_addr_wren", 32'(wrCnt), 32'd0);

    clrMon();
    bus.TX_BUSY = 1'b1;
    sendByte(8'hBB);
    sendByte(8'h07);
    waitTxVld();
    sendByte(8'h77);
    bus.TX_BUSY = 1'b0;
    waitTx(2);
    chk("send_rx_err", 32'(errCnt), 32'd1);
    chk("send_rx_ntx", 32'(txQ.size()), 32'd2);
    chk("send_rx_tx0", 32'(txAt(0)), 32'h01);
    chk("send_rx_tx1", 32'(txAt(1)), 32'h00);

    clrMon();
    sendByte(8'hAA);
    sendByte(8'h05);
    sendByte(8'hFF);
    rst = 1'b1;
    #2;
    chk("midrst_outs",
        32'({bus.WrEn, bus.RdEn, bus.Address, bus.WrData,
             bus.TX_P_DATA, bus.TX_D_VLD, bus.ERR}), 32'd0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("midrst_wren", 32'(wrCnt), 32'd0);
    doWrite("wr5", 8'h05, 8'h12, 8'h34, 16'h3412);
    doRead("rd5", 8'h05, 8'h12, 8'h34);

`ifdef REG_CMD_CTRL_TIMEOUT_EN
    clrMon();
    sendByte(8'hAA);
    sendByte(8'h02);
    step(20);
    chk("to_err", 32'(errCnt), 32'd1);
    chk("to_wren", 32'(wrCnt), 32'd0);
    doWrite("to_wr2", 8'h02, 8'h44, 8'h00, 16'h0044);
`endif

    chk("no_overlap", 32'(bothCnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
